// File: rtl/jk_bank_arbiter_if.sv
// Command channel from one requester into the JK bank arbiter:
// a per-bit JK op with a valid/ready handshake.
interface jk_bank_arbiter_if #(
  parameter int IDX_W = 3
);
  logic             valid;
  logic [IDX_W-1:0] idx;
  logic [1:0]       op;
  logic             ready;

  modport master (output valid, output idx, output op, input  ready);
  modport slave  (input  valid, input  idx, input  op, output ready);
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter between two requesters that applies one JK command
// per grant to an internal bank of JK cells and reports completion.
module jk_bank_arbiter #(
  parameter int NBITS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_arbiter_if.slave a,
  jk_bank_arbiter_if.slave b,
  output logic [NBITS-1:0] q,
  output logic [NBITS-1:0] qbar,
  output logic             j_mon,
  output logic             k_mon,
  output logic             done,
  output logic             done_src,
  output logic             done_q,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, APPLY, RESP} state_e;
  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  state_e           state_q, state_d;
  src_e             last_q, last_d;
  src_e             src_q, src_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [NBITS-1:0] bank_q, bank_d;

  logic             grant_a, grant_b;
  logic             in_range;
  logic [NBITS-1:0] sel;

  // Out-of-range targets select no cell, so they leave the bank untouched.
  assign in_range = 32'(idx_q) < NBITS;
  assign sel      = in_range ? (NBITS'(1) << idx_q) : '0;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE) begin
      if (a.valid && (!b.valid || last_q == SRC_B)) grant_a = 1'b1;
      else if (b.valid)                              grant_b = 1'b1;
    end
  end

  assign a.ready = grant_a;
  assign b.ready = grant_b;
  assign q       = bank_q;
  assign qbar    = ~bank_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    last_d   = last_q;
    src_d    = src_q;
    idx_d    = idx_q;
    op_d     = op_q;
    bank_d   = bank_q;
    j_mon    = 1'b0;
    k_mon    = 1'b0;
    done     = 1'b0;
    done_src = 1'b0;
    done_q   = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_a) begin
          idx_d   = a.idx;
          op_d    = a.op;
          src_d   = SRC_A;
          last_d  = SRC_A;
          state_d = APPLY;
        end else if (grant_b) begin
          idx_d   = b.idx;
          op_d    = b.op;
          src_d   = SRC_B;
          last_d  = SRC_B;
          state_d = APPLY;
        end
      end
      APPLY: begin
        j_mon = op_q[1];
        k_mon = op_q[0];
        unique case (op_q)
          2'b01:   bank_d = bank_q & ~sel;
          2'b10:   bank_d = bank_q | sel;
          2'b11:   bank_d = bank_q ^ sel;
          default: bank_d = bank_q;
        endcase
        state_d = RESP;
      end
      RESP: begin
        done     = 1'b1;
        done_src = (src_q == SRC_B);
        done_q   = |(bank_q & sel);
        err      = !in_range;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the bank is a handful of flops with a defined reset value, not a RAM, so it is reset with the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= SRC_B;
      src_q   <= SRC_A;
      idx_q   <= '0;
      op_q    <= '0;
      bank_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
    end
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Arbitrated command controller for a bank of JK flip-flops. Two requesters issue per-bit JK commands (hold/reset/set/toggle) over valid/ready handshakes; the block arbitrates round-robin, sequences each accepted command through a one-cycle apply phase on the internal JK register bank, and reports completion. It sits between control agents and the JK state bank, giving shared, ordered access to it.

## Interface
- `NBITS`, 8: number of JK cells in the bank.
- `IDX_W`, 3: index width; must satisfy 2^IDX_W >= NBITS.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `a_valid`  in  1  requester A command valid.
- `a_idx`  in  IDX_W  requester A target bit.
- `a_op`  in  2  requester A op: 00 hold (j=0,k=0), 01 reset (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1).
- `a_ready`  out  1  requester A command accepted this cycle when high with `a_valid`.
- `b_valid`, `b_idx`, `b_op`, `b_ready`: same as A, for requester B.
- `q`  out  NBITS  bank state.
- `qbar`  out  NBITS  always bitwise inverse of `q`.
- `j_mon`, `k_mon`  out  1 each  j/k being applied in APPLY; 0 otherwise.
- `done`  out  1  one-cycle completion pulse.
- `done_src`  out  1  0 = A, 1 = B; valid with `done`.
- `done_q`  out  1  post-command value of the target bit; valid with `done`.
- `err`  out  1  high with `done` when the index was >= NBITS.

## Operation
- FSM states: IDLE, APPLY, RESP.
- IDLE: grant computed combinationally. Only A valid -> A; only B valid -> B; both -> requester not served last. `last` pointer resets to B, so A wins the first tie. Only the granted requester's ready is high, and only in IDLE; both readies low in APPLY and RESP.
- Handshake (valid & ready at edge): latch idx, op, source; update `last`; go APPLY.
- APPLY (one cycle): `j_mon`/`k_mon` drive the decoded op. At the closing edge the target bit updates per JK rule: 00 keep, 01 -> 0, 10 -> 1, 11 -> invert. Other bits unchanged. Go RESP.
- RESP (one cycle): `done`=1, `done_src`, `done_q`=new target bit, `err`. Go IDLE.
- Out-of-range idx (>= NBITS): accepted normally, no bit changes, `err`=1 in RESP, `done_q`=0.
- Requesters hold valid/idx/op stable until accepted; the block does not sample unaccepted inputs.
- Reset (rst low, any state, asynchronous): state IDLE, `q`=0, `qbar`=all ones, `j_mon`=`k_mon`=0, `done`=`done_src`=`done_q`=`err`=0, `last`=B. In-flight command discarded, no partial bit update. Readies follow IDLE grant once rst is high.

## Timing
- Handshake at edge E0 -> APPLY during E0..E1 -> `q` updates at E1 -> `done` high E1..E2 -> IDLE after E2.
- Next handshake earliest at E3. Maximum throughput is one command per 3 cycles.
- Latency from accept to updated `q`: 1 edge. Latency from accept to `done`: 1 cycle.
- `qbar` always equals ~`q`, including during reset.
- Requester waiting under a tie is served at most one command later; there is no starvation.

## Test plan
- Reset: rst low mid-APPLY of a set on bit 2 -> `q`=0x00, `qbar`=0xFF, no `done`; after release, A alone accepted first.
- Single requester: A sends set idx 3, then toggle idx 3, then reset idx 3, then toggle idx 3 -> `q` 0x08, 0x00, 0x00, 0x08; each `done` with `done_src`=0 and `done_q` 1, 0, 0, 1.
- Tie arbitration: A and B both valid continuously (A set idx 0, B set idx 7) -> grant order A, B, A, B; readies never both high; `q`=0x81 after the first two completions.
- Hold op: B sends hold idx 5 with `q`=0x20 -> `q` unchanged, `j_mon`=`k_mon`=0 in APPLY, `done_q`=1.
- Out of range: NBITS=6, A sends set idx 7 -> `q` unchanged, `done`=1, `err`=1.
- Throughput: back-to-back valid on A -> ready high exactly every third cycle; `done` pulses are spaced 3 cycles apart.
